// File: rtl/dqpsk_pkg.sv
// Shared widths and width-derivation helpers for the DQPSK demod datapath.
// No ports; imported by the mixer and integrate-and-dump stages.
package dqpsk_pkg;

  localparam int DIN_W_DEF = 8;
  localparam int NCO_W_DEF = 10;
  localparam int OUT_W_DEF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int prod_w(input int dw,
                                input int nw);
    return dw + nw;
  endfunction

  function automatic int acc_w(input int pw,
                               input int n);
    return pw + clog2(n);
  endfunction

endpackage

// File: rtl/cmplx_mix.sv
// Registered signed mixer pair: pi = din*cos, pq = -(din*sin).
// Ports: clk/rst, en_i (accept), din_i, cos_i, sin_i -> pi_o, pq_o, pv_o.
module cmplx_mix
  import dqpsk_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int NCO_W  = NCO_W_DEF,
  parameter int PROD_W = prod_w(DIN_W, NCO_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [DIN_W-1:0]  din_i,
  input  logic signed [NCO_W-1:0]  cos_i,
  input  logic signed [NCO_W-1:0]  sin_i,
  output logic signed [PROD_W-1:0] pi_o,
  output logic signed [PROD_W-1:0] pq_o,
  output logic                     pv_o
);

  logic signed [PROD_W-1:0] pi_d, pi_q;
  logic signed [PROD_W-1:0] pq_d, pq_q;
  logic                     pv_q;

  // Full-precision products; the negated extreme still fits PROD_W.
  assign pi_d = din_i * cos_i;
  assign pq_d = -(din_i * sin_i);

  // pv marks a fresh product; held products are never re-accumulated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pi_q <= '0;
      pq_q <= '0;
      pv_q <= 1'b0;
    end else begin
      pv_q <= en_i;
      if (en_i) begin
        pi_q <= pi_d;
        pq_q <= pq_d;
      end
    end
  end

  assign pi_o = pi_q;
  assign pq_o = pq_q;
  assign pv_o = pv_q;

endmodule

// File: rtl/ddc_mix_dump.sv
// Quadrature down-conversion plus integrate-and-dump over DUMP_LEN samples.
// Ports: din/nco inputs with valids, sync_clr -> i_out, q_out, dout_valid.
module ddc_mix_dump
  import dqpsk_pkg::*;
#(
  parameter int DIN_W    = DIN_W_DEF,
  parameter int NCO_W    = NCO_W_DEF,
  parameter int DUMP_LEN = 8,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_valid,
  input  logic signed [NCO_W-1:0] nco_cos,
  input  logic signed [NCO_W-1:0] nco_sin,
  input  logic                    nco_valid,
  input  logic                    sync_clr,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    dout_valid
);

  localparam int PROD_W = prod_w(DIN_W, NCO_W);
  localparam int ACC_W  = acc_w(PROD_W, DUMP_LEN);
  localparam int CW     = clog2(DUMP_LEN);
  localparam logic [CW-1:0] LAST = CW'(DUMP_LEN - 1);

  logic signed [PROD_W-1:0] pi, pq;
  logic                     pv;

  cmplx_mix #(
    .DIN_W (DIN_W),
    .NCO_W (NCO_W)
  ) u_mix (
    .clk   (clk),
    .rst   (rst),
    .en_i  (din_valid & nco_valid),
    .din_i (din),
    .cos_i (nco_cos),
    .sin_i (nco_sin),
    .pi_o  (pi),
    .pq_o  (pq),
    .pv_o  (pv)
  );

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i_d, sum_q_d;
  logic [CW-1:0]           cnt_q;
  logic signed [OUT_W-1:0] i_q, q_q;
  logic                    dv_q;
  logic                    dump_d;

  assign sum_i_d = acc_i_q
                 + {{(ACC_W-PROD_W){pi[PROD_W-1]}}, pi};
  assign sum_q_d = acc_q_q
                 + {{(ACC_W-PROD_W){pq[PROD_W-1]}}, pq};

  // sync_clr drops the pending product and any dump it would cause.
  assign dump_d = pv & ~sync_clr & (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= dump_d;
      if (sync_clr) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
        cnt_q   <= '0;
      end else if (dump_d) begin
        i_q     <= sum_i_d[ACC_W-1 -: OUT_W];
        q_q     <= sum_q_d[ACC_W-1 -: OUT_W];
        acc_i_q <= '0;
        acc_q_q <= '0;
        cnt_q   <= '0;
      end else if (pv) begin
        acc_i_q <= sum_i_d;
        acc_q_q <= sum_q_d;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign i_out      = i_q;
  assign q_out      = q_q;
  assign dout_valid = dv_q;

endmodule

// File: tb/tb_ddc_mix_dump.sv
// Self-checking bench for ddc_mix_dump: window-sum model plus directed checks.
// Drives inputs 1ns after posedge, compares outputs on every negedge.
module tb_ddc_mix_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [7:0]  din = '0;
  logic               din_valid = 1'b0;
  logic signed [9:0]  nco_cos = '0;
  logic signed [9:0]  nco_sin = '0;
  logic               nco_valid = 1'b0;
  logic               sync_clr = 1'b0;
  logic signed [15:0] i_out, q_out;
  logic               dout_valid;

  ddc_mix_dump #(
    .DIN_W(8), .NCO_W(10), .DUMP_LEN(8), .OUT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .nco_cos(nco_cos), .nco_sin(nco_sin), .nco_valid(nco_valid),
    .sync_clr(sync_clr), .i_out(i_out), .q_out(q_out),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a window is the list of accepted samples since the last dump,
  // sync_clr or reset. The 8th sample's sums appear 2 cycles later unless
  // a sync_clr lands in the cycle between.
  int     win_n;
  longint win_i, win_q;
  bit     pend;
  longint pend_i, pend_q;
  bit                 exp_dv;
  logic signed [15:0] exp_i, exp_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win_n = 0; win_i = 0; win_q = 0;
      pend = 0; pend_i = 0; pend_q = 0;
      exp_dv = 0; exp_i = '0; exp_q = '0;
    end else begin
      exp_dv = 0;
      if (pend && !sync_clr) begin
        exp_dv = 1;
        exp_i = 16'(pend_i >>> 5);
        exp_q = 16'(pend_q >>> 5);
      end
      pend = 0;
      if (sync_clr) begin
        win_n = 0; win_i = 0; win_q = 0;
      end
      if (din_valid && nco_valid) begin
        win_i += longint'(din) * longint'(nco_cos);
        win_q -= longint'(din) * longint'(nco_sin);
        win_n++;
        if (win_n == 8) begin
          pend = 1; pend_i = win_i; pend_q = win_q;
          win_n = 0; win_i = 0; win_q = 0;
        end
      end
    end
  end

  int st_cyc[$];
  int st_i[$];
  int st_q[$];

  always @(negedge clk) begin
    tests++;
    if (dout_valid !== exp_dv || i_out !== exp_i || q_out !== exp_q) begin
      fails++;
      $display("FAIL cyc%0d model: got dv=%0b i=%0d q=%0d want dv=%0b i=%0d q=%0d",
               cyc, dout_valid, i_out, q_out, exp_dv, exp_i, exp_q);
    end
    if (dout_valid === 1'b1) begin
      st_cyc.push_back(cyc);
      st_i.push_back(int'(i_out));
      st_q.push_back(int'(q_out));
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic cy(input bit dv, input bit nv, input int d,
                    input int c, input int s, input bit clr);
    din_valid = dv; nco_valid = nv;
    din = 8'(d); nco_cos = 10'(c); nco_sin = 10'(s);
    sync_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cy(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clrq();
    st_cyc.delete(); st_i.delete(); st_q.delete();
  endtask

  int t8, t8b, t16;

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_dv", dout_valid, 0);
    chk("reset_i", i_out, 0);
    rst = 0;
    idle(2);

    // Constant cos tone: 408800 >>> 5 = 12775.
    clrq();
    for (int k = 0; k < 16; k++) begin
      if (k == 7) t8 = cyc;
      cy(1, 1, 100, 511, 0, 0);
    end
    idle(3);
    chk("const_nstrobe", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      chk("const_i", st_i[0], 12775);
      chk("const_q", st_q[0], 0);
      chk("const_lat", st_cyc[0], t8 + 2);
      chk("const_space", st_cyc[1] - st_cyc[0], 8);
    end

    // Extreme negative products on Q.
    clrq();
    for (int k = 0; k < 8; k++) cy(1, 1, -128, 0, -512, 0);
    idle(3);
    chk("ext_nstrobe", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      chk("ext_q", st_q[0], -16384);
      chk("ext_i", st_i[0], 0);
    end

    // din_valid toggling stretches the window to 16 cycles.
    clrq();
    for (int k = 0; k < 32; k++) begin
      if (k == 14) t8 = cyc;
      cy(~k[0], 1, 100, 511, 0, 0);
    end
    idle(3);
    chk("gap_nstrobe", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      chk("gap_i", st_i[1], 12775);
      chk("gap_lat", st_cyc[0], t8 + 2);
      chk("gap_space", st_cyc[1] - st_cyc[0], 16);
    end

    // nco_valid low for 3 cycles while din_valid stays high.
    clrq();
    for (int k = 0; k < 11; k++) begin
      if (k == 10) t8 = cyc;
      cy(1, !(k >= 2 && k <= 4), 100, 511, 0, 0);
    end
    idle(3);
    chk("ncov_nstrobe", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      chk("ncov_lat", st_cyc[0], t8 + 2);
      chk("ncov_i", st_i[0], 12775);
    end

    // sync_clr with a coincident sample: that sample starts the window.
    clrq();
    for (int k = 0; k < 3; k++) cy(1, 1, 50, 300, 200, 0);
    cy(1, 1, 100, 511, 0, 1);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) t8 = cyc;
      cy(1, 1, 100, 511, 0, 0);
    end
    idle(3);
    chk("clr_nstrobe", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      chk("clr_lat", st_cyc[0], t8 + 2);
      chk("clr_i", st_i[0], 12775);
      chk("clr_q", st_q[0], 0);
    end

    // sync_clr in the dump cycle suppresses the strobe.
    clrq();
    for (int k = 0; k < 8; k++) cy(1, 1, 30, 100, 100, 0);
    cy(0, 0, 0, 0, 0, 1);
    idle(3);
    chk("sup_nstrobe", st_cyc.size(), 0);
    chk("sup_hold_i", i_out, 12775);

    // Reset mid-strobe, then 8 fresh samples are needed.
    for (int k = 0; k < 8; k++) cy(1, 1, 100, 511, 0, 0);
    cy(0, 0, 0, 0, 0, 0);
    chk("pre_rst_dv", dout_valid, 1);
    #1 rst = 1;
    #1;
    chk("rst_dv", dout_valid, 0);
    chk("rst_i", i_out, 0);
    @(posedge clk); #1;
    rst = 0;
    clrq();
    for (int k = 0; k < 3; k++) cy(1, 1, 100, 511, 0, 0);
    #1 rst = 1;
    #1;
    chk("rst_mid_i", i_out, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 7; k++) cy(1, 1, 100, 511, 0, 0);
    idle(3);
    chk("rst_7_nstrobe", st_cyc.size(), 0);
    t16 = cyc;
    cy(1, 1, 100, 511, 0, 0);
    idle(3);
    chk("rst_8_nstrobe", st_cyc.size(), 1);
    if (st_cyc.size() == 1) chk("rst_8_lat", st_cyc[0], t16 + 2);

    // Randomized traffic checked by the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
      end
      cy($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
         int'($urandom), int'($urandom), int'($urandom),
         $urandom_range(0, 39) == 0);
    end
    idle(4);
    t8b = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
